power2round_stream: RTL

//  Streaming, multi-lane Power2Round for the ML-DSA/Dilithium keygen datapath. Splits each t in [0,Q) into
//  t1 = round-up high part and t0 = low part, in either the packed-offset form 2^(D-1)-t0c or centred signed t0c.

---
 rtl/power2round_stream.sv | 122 ++++++++++++
 1 files changed

// File: rtl/power2round_stream.sv
// Multi-lane Power2Round (t -> t1, t0) with per-polynomial beat counter and range flags.
// Latency 2 cycles; 2-stage elastic valid/ready pipeline, outputs hold while stalled.
module power2round_stream #(
  parameter int WIDTH = 24,
  parameter int D     = 13,
  parameter int T1_W  = 10,
  parameter int LANES = 4,
  parameter int N     = 256,
  parameter int Q     = 8380417
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [LANES*WIDTH-1:0]   i_data,
  input  logic                     i_mode,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [LANES*T1_W-1:0]    o_t1,
  output logic [LANES*(D+1)-1:0]   o_t0,
  output logic [LANES-1:0]         o_err,
  output logic                     o_last
);

  localparam int BEATS = N / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HW    = WIDTH - D;
  localparam logic [WIDTH-1:0] Q_W      = WIDTH'(Q);
  localparam logic [D-1:0]     H_R      = {1'b1, {(D-1){1'b0}}};
  localparam logic [D:0]       H_T      = {2'b01, {(D-1){1'b0}}};
  localparam logic [CW-1:0]    CNT_LAST = CW'(BEATS - 1);

  logic                          r_s1_vld;
  logic [LANES-1:0][D-1:0]       r_s1_r0;
  logic [LANES-1:0][HW-1:0]      r_s1_hi;
  logic [LANES-1:0]              r_s1_err;
  logic                          r_s1_last;
  logic                          r_s1_mode;
  logic                          r_s2_vld;
  logic [CW-1:0]                 r_cnt;
  logic                          r_mode;

  logic [LANES-1:0][WIDTH-1:0]   w_in;
  logic                          w_acc;
  logic                          w_s2_ld;
  logic                          w_cnt_last;
  logic                          w_mode;
  logic [LANES-1:0]              w_up;
  logic [LANES-1:0][WIDTH-1:0]   w_t1_full;
  logic [LANES-1:0][D:0]         w_t0c;
  logic [LANES-1:0][T1_W-1:0]    w_t1;
  logic [LANES-1:0][D:0]         w_t0;

  assign w_in       = i_data;
  assign w_s2_ld    = !r_s2_vld || i_ready;
  assign o_ready    = !r_s1_vld || w_s2_ld;
  assign o_valid    = r_s2_vld;
  assign w_acc      = i_valid && o_ready;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_mode     = (r_cnt == '0) ? i_mode : r_mode;

  // r0 - 2^D modulo 2^(D+1) is just {1, r0}, so the centred t0 needs no subtractor.
  always_comb begin
    w_up      = '0;
    w_t1_full = '0;
    w_t0c     = '0;
    w_t1      = '0;
    w_t0      = '0;
    for (int k = 0; k < LANES; k++) begin
      w_up[k]      = (r_s1_r0[k] > H_R);
      w_t1_full[k] = WIDTH'(r_s1_hi[k]) + WIDTH'(w_up[k]);
      w_t1[k]      = w_t1_full[k][T1_W-1:0];
      w_t0c[k]     = {w_up[k], r_s1_r0[k]};
      w_t0[k]      = r_s1_mode ? w_t0c[k] : (H_T - w_t0c[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_r0   <= '0;
      r_s1_hi   <= '0;
      r_s1_err  <= '0;
      r_s1_last <= 1'b0;
      r_s1_mode <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      o_t1      <= '0;
      o_t0      <= '0;
      o_err     <= '0;
      o_last    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_cnt  <= w_cnt_last ? '0 : r_cnt + CW'(1);
        r_mode <= w_mode;
      end
      if (o_ready) begin
        r_s1_vld <= i_valid;
        if (i_valid) begin
          for (int k = 0; k < LANES; k++) begin
            r_s1_r0[k]  <= w_in[k][D-1:0];
            r_s1_hi[k]  <= w_in[k][WIDTH-1:D];
            r_s1_err[k] <= (w_in[k] >= Q_W);
          end
          r_s1_last <= w_cnt_last;
          r_s1_mode <= w_mode;
        end
      end
      if (w_s2_ld) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          o_t1   <= w_t1;
          o_t0   <= w_t0;
          o_err  <= r_s1_err;
          o_last <= r_s1_last;
        end
      end
    end
  end

endmodule
